// File: rtl/cache_req_arbiter_if.sv
// Bundles the requester-side and cache-side buses of the cache request arbiter.
// "master" is the arbiter's view: it masters the cache port and answers the requesters.
// "slave" is the environment's view: requesters plus the cache controller.
interface cache_req_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 7,
  parameter int DW   = 8
);
  // requester side
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_hit;
  logic               rsp_err;
  logic               busy;

  // cache controller side
  logic               c_valid;
  logic               c_we;
  logic [AW-1:0]      c_addr;
  logic [DW-1:0]      c_wdata;
  logic               c_ready;
  logic               c_rvalid;
  logic [DW-1:0]      c_rdata;
  logic               c_hit;

  modport master (
    input  req, req_we, req_addr, req_wdata,
    input  c_ready, c_rvalid, c_rdata, c_hit,
    output gnt, done, rsp_rdata, rsp_hit, rsp_err, busy,
    output c_valid, c_we, c_addr, c_wdata
  );

  modport slave (
    output req, req_we, req_addr, req_wdata,
    output c_ready, c_rvalid, c_rdata, c_hit,
    input  gnt, done, rsp_rdata, rsp_hit, rsp_err, busy,
    input  c_valid, c_we, c_addr, c_wdata
  );
endinterface

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one cache controller port among NREQ
// requesters. One transaction in flight at a time: IDLE picks an owner,
// ISSUE handshakes the request, WAIT collects the response, RESP returns it.
// A saturating counter aborts a transaction that stalls in ISSUE/WAIT.
module cache_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 7,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  cache_req_arbiter_if.master bus
);

  localparam int              IW       = $clog2(NREQ);
  localparam int              CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(TIMEOUT);
  localparam logic [IW:0]     NREQ_W   = (IW+1)'(NREQ);
  localparam logic [IW-1:0]   LAST_RST = IW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE      = NREQ'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state_reg;
  logic [IW-1:0]   owner_reg;
  logic [IW-1:0]   last_reg;
  logic [CW-1:0]   cnt_reg;
  logic [NREQ-1:0] gnt_reg;
  logic [NREQ-1:0] done_reg;
  logic [DW-1:0]   rsp_rdata_reg;
  logic            rsp_hit_reg;
  logic            rsp_err_reg;
  logic            busy_reg;
  logic            c_valid_reg;
  logic            c_we_reg;
  logic [AW-1:0]   c_addr_reg;
  logic [DW-1:0]   c_wdata_reg;

  // per-requester views of the packed address/data buses
  logic [AW-1:0]   addr_arr  [NREQ];
  logic [DW-1:0]   wdata_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = bus.req_addr[gi*AW +: AW];
    assign wdata_arr[gi] = bus.req_wdata[gi*DW +: DW];
  end

  // round-robin pick: scan from last+1 upward, wrapping, first set req wins
  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic [IW:0]     cand;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      // last+k never exceeds 2*NREQ-1, so a single conditional subtract wraps it
      cand = {1'b0, last_reg} + (IW+1)'(k);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (!pick_found && bus.req[cand[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IW-1:0];
      end
    end
  end

  // timeout counter helpers: saturate at TIMEOUT so a late cycle cannot wrap
  logic          timeout_hit;
  logic [CW-1:0] cnt_inc;

  assign timeout_hit = (cnt_reg == CNT_MAX);
  assign cnt_inc     = timeout_hit ? cnt_reg : cnt_reg + 1'b1;

  // transaction sequencer with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      owner_reg     <= '0;
      last_reg      <= LAST_RST;
      cnt_reg       <= '0;
      gnt_reg       <= '0;
      done_reg      <= '0;
      rsp_rdata_reg <= '0;
      rsp_hit_reg   <= 1'b0;
      rsp_err_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      c_valid_reg   <= 1'b0;
      c_we_reg      <= 1'b0;
      c_addr_reg    <= '0;
      c_wdata_reg   <= '0;
    end else begin
      // gnt and done are single-cycle pulses
      gnt_reg  <= '0;
      done_reg <= '0;
      case (state_reg)
        S_IDLE: begin
          if (pick_found) begin
            owner_reg   <= pick_idx;
            last_reg    <= pick_idx;
            c_we_reg    <= bus.req_we[pick_idx];
            c_addr_reg  <= addr_arr[pick_idx];
            c_wdata_reg <= wdata_arr[pick_idx];
            gnt_reg     <= ONE << pick_idx;
            cnt_reg     <= '0;
            c_valid_reg <= 1'b1;
            busy_reg    <= 1'b1;
            state_reg   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_reg <= cnt_inc;
          // an accepted handshake wins over a coincident timeout: the cache owns it now
          if (bus.c_ready) begin
            c_valid_reg <= 1'b0;
            state_reg   <= S_WAIT;
          end else if (timeout_hit) begin
            c_valid_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_hit_reg   <= 1'b0;
            rsp_err_reg   <= 1'b1;
            done_reg      <= ONE << owner_reg;
            state_reg     <= S_RESP;
          end
        end
        S_WAIT: begin
          cnt_reg <= cnt_inc;
          // a response arriving on the timeout cycle is still honoured
          if (bus.c_rvalid) begin
            rsp_rdata_reg <= bus.c_rdata;
            rsp_hit_reg   <= bus.c_hit;
            rsp_err_reg   <= 1'b0;
            done_reg      <= ONE << owner_reg;
            state_reg     <= S_RESP;
          end else if (timeout_hit) begin
            rsp_rdata_reg <= '0;
            rsp_hit_reg   <= 1'b0;
            rsp_err_reg   <= 1'b1;
            done_reg      <= ONE << owner_reg;
            state_reg     <= S_RESP;
          end
        end
        S_RESP: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          busy_reg    <= 1'b0;
          c_valid_reg <= 1'b0;
          state_reg   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_reg;
  assign bus.done      = done_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_hit   = rsp_hit_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.busy      = busy_reg;
  assign bus.c_valid   = c_valid_reg;
  assign bus.c_we      = c_we_reg;
  assign bus.c_addr    = c_addr_reg;
  assign bus.c_wdata   = c_wdata_reg;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Bench for cache_req_arbiter. A transaction-level model predicts the winner
// (round-robin from the last owner), the cycle of done and the response from
// the cache delays the bench chooses; every DUT output is checked each cycle.
module tb_cache_req_arbiter;
  localparam int NREQ    = 4;
  localparam int AW      = 7;
  localparam int DW      = 8;
  localparam int TIMEOUT = 15;

  logic clk;
  logic rst_n;

  cache_req_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  cache_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cmp_cnt  = 0;
  int fail_cnt = 0;
  int txn_no   = 0;

  // requester-side stimulus state
  logic [NREQ-1:0] req_v;
  logic            we_a    [NREQ];
  logic [AW-1:0]   addr_a  [NREQ];
  logic [DW-1:0]   wdata_a [NREQ];

  // reference model state
  int              last_m;
  logic [DW-1:0]   m_rdata;
  logic            m_hit;
  logic            m_err;

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic push_req();
    bus.req = req_v;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_we[i]              = we_a[i];
      bus.req_addr[i*AW +: AW]   = addr_a[i];
      bus.req_wdata[i*DW +: DW]  = wdata_a[i];
    end
  endtask

  task automatic shuffle_fields();
    for (int i = 0; i < NREQ; i++) begin
      we_a[i]    = 1'($urandom);
      addr_a[i]  = AW'($urandom);
      wdata_a[i] = DW'($urandom);
    end
  endtask

  task automatic model_reset();
    last_m  = NREQ - 1;
    m_rdata = '0;
    m_hit   = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.c_ready  = 1'b0;
    bus.c_rvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One transaction. Entered at the negedge of an IDLE cycle (cycle 0) with
  // req_v set; returns at the negedge of the IDLE cycle after RESP.
  // d_r: ISSUE cycles before c_ready; d_v: WAIT cycles before c_rvalid.
  task automatic run_txn(input int d_r, input bit never_ready, input int d_v,
                         input logic [DW-1:0] rdata, input logic hit,
                         input bit keep_req, input bit stray, output int owner);
    int              issue_end;
    int              d_cyc;
    int              rv_cyc;
    bit              accepted;
    logic            exp_we;
    logic [AW-1:0]   exp_addr;
    logic [DW-1:0]   exp_wdata;
    logic [DW-1:0]   exp_rdata;
    logic            exp_hit;
    logic            exp_err;
    logic [NREQ-1:0] exp_gnt;
    logic [NREQ-1:0] exp_done;
    logic            exp_busy;
    logic            exp_cv;

    if (req_v == '0) req_v[0] = 1'b1;
    owner = -1;
    for (int k = 1; k <= NREQ; k++) begin
      if (owner < 0 && req_v[(last_m + k) % NREQ]) owner = (last_m + k) % NREQ;
    end
    last_m    = owner;
    exp_we    = we_a[owner];
    exp_addr  = addr_a[owner];
    exp_wdata = wdata_a[owner];

    if (never_ready) begin
      issue_end = TIMEOUT + 1;
      accepted  = 1'b0;
      rv_cyc    = -1;
    end else begin
      issue_end = d_r + 1;
      accepted  = (d_r + 1 + d_v <= TIMEOUT);
      rv_cyc    = d_r + 2 + d_v;
    end
    d_cyc     = accepted ? d_r + d_v + 3 : TIMEOUT + 2;
    exp_rdata = accepted ? rdata : '0;
    exp_hit   = accepted ? hit : 1'b0;
    exp_err   = !accepted;

    // cycle 0 inputs
    push_req();
    bus.c_ready  = 1'b0;
    bus.c_rvalid = stray;
    bus.c_rdata  = DW'($urandom);
    bus.c_hit    = 1'($urandom);

    for (int c = 1; c <= d_cyc + 1; c++) begin
      @(negedge clk);
      exp_gnt  = (c == 1) ? onehot(owner) : '0;
      exp_done = (c == d_cyc) ? onehot(owner) : '0;
      exp_busy = (c <= d_cyc);
      exp_cv   = (c <= issue_end);

      cmp_cnt++;
      if (bus.gnt !== exp_gnt) begin
        fail_cnt++;
        $display("FAIL gnt txn %0d cyc %0d: got %b expected %b", txn_no, c, bus.gnt, exp_gnt);
      end
      cmp_cnt++;
      if (bus.done !== exp_done) begin
        fail_cnt++;
        $display("FAIL done txn %0d cyc %0d: got %b expected %b", txn_no, c, bus.done, exp_done);
      end
      cmp_cnt++;
      if (bus.busy !== exp_busy) begin
        fail_cnt++;
        $display("FAIL busy txn %0d cyc %0d: got %b expected %b", txn_no, c, bus.busy, exp_busy);
      end
      cmp_cnt++;
      if (bus.c_valid !== exp_cv) begin
        fail_cnt++;
        $display("FAIL c_valid txn %0d cyc %0d: got %b expected %b", txn_no, c, bus.c_valid, exp_cv);
      end
      if (exp_cv) begin
        cmp_cnt++;
        if ({bus.c_we, bus.c_addr, bus.c_wdata} !== {exp_we, exp_addr, exp_wdata}) begin
          fail_cnt++;
          $display("FAIL c_fields txn %0d cyc %0d: got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                   txn_no, c, bus.c_we, bus.c_addr, bus.c_wdata, exp_we, exp_addr, exp_wdata);
        end
      end
      if (c == 1) begin
        cmp_cnt++;
        if ({bus.rsp_rdata, bus.rsp_hit, bus.rsp_err} !== {m_rdata, m_hit, m_err}) begin
          fail_cnt++;
          $display("FAIL rsp_hold txn %0d: got %h/%b/%b expected %h/%b/%b", txn_no,
                   bus.rsp_rdata, bus.rsp_hit, bus.rsp_err, m_rdata, m_hit, m_err);
        end
      end
      if (c == d_cyc) begin
        cmp_cnt++;
        if (bus.rsp_rdata !== exp_rdata) begin
          fail_cnt++;
          $display("FAIL rsp_rdata txn %0d: got %h expected %h", txn_no, bus.rsp_rdata, exp_rdata);
        end
        cmp_cnt++;
        if (bus.rsp_hit !== exp_hit) begin
          fail_cnt++;
          $display("FAIL rsp_hit txn %0d: got %b expected %b", txn_no, bus.rsp_hit, exp_hit);
        end
        cmp_cnt++;
        if (bus.rsp_err !== exp_err) begin
          fail_cnt++;
          $display("FAIL rsp_err txn %0d: got %b expected %b", txn_no, bus.rsp_err, exp_err);
        end
      end

      // inputs for cycle c; requester fields change once latched
      if (c == 1) begin
        if (!keep_req) req_v[owner] = 1'b0;
        shuffle_fields();
        push_req();
      end
      bus.c_ready  = (!never_ready && c == d_r + 1);
      bus.c_rvalid = (c == rv_cyc) || (stray && c <= issue_end);
      bus.c_rdata  = (c == rv_cyc) ? rdata : DW'($urandom);
      bus.c_hit    = (c == rv_cyc) ? hit : 1'($urandom);
    end

    m_rdata = exp_rdata;
    m_hit   = exp_hit;
    m_err   = exp_err;
    $display("txn %0d: owner=%0d we=%0b addr=%h wdata=%h d_r=%0d d_v=%0d nr=%0b done_cyc=%0d err=%0b rdata=%h",
             txn_no, owner, exp_we, exp_addr, exp_wdata, d_r, d_v, never_ready, d_cyc, exp_err, exp_rdata);
    txn_no++;
  endtask

  // idle cycles with no request; optional stray c_rvalid must be ignored
  task automatic idle_cycles(input int n, input bit stray);
    req_v = '0;
    push_req();
    for (int i = 0; i < n; i++) begin
      bus.c_ready  = 1'b0;
      bus.c_rvalid = stray;
      bus.c_rdata  = DW'($urandom);
      @(negedge clk);
      cmp_cnt++;
      if ({bus.gnt, bus.done, bus.busy} !== '0) begin
        fail_cnt++;
        $display("FAIL idle: got gnt=%b done=%b busy=%b expected all 0", bus.gnt, bus.done, bus.busy);
      end
    end
    bus.c_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_v = '0;
    for (int i = 0; i < NREQ; i++) begin
      we_a[i] = 1'b0; addr_a[i] = '0; wdata_a[i] = '0;
    end
    push_req();
    bus.c_ready  = 1'b0;
    bus.c_rvalid = 1'b0;
    bus.c_rdata  = '0;
    bus.c_hit    = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    cmp_cnt++;
    if ({bus.gnt, bus.done, bus.busy, bus.c_valid, bus.c_we, bus.c_addr, bus.c_wdata,
         bus.rsp_rdata, bus.rsp_hit, bus.rsp_err} !== '0) begin
      fail_cnt++;
      $display("FAIL reset_state: got gnt=%b done=%b busy=%b c_valid=%b c_we=%b c_addr=%h c_wdata=%h rsp=%h/%b/%b expected all 0",
               bus.gnt, bus.done, bus.busy, bus.c_valid, bus.c_we, bus.c_addr, bus.c_wdata,
               bus.rsp_rdata, bus.rsp_hit, bus.rsp_err);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    int owner;
    req_v      = 4'b0001;
    we_a[0]    = 1'b1;
    addr_a[0]  = 7'h04;
    wdata_a[0] = 8'h5A;
    run_txn(0, 1'b0, 0, 8'h11, 1'b1, 1'b0, 1'b0, owner);
    cmp_cnt++;
    if (owner != 0) begin
      fail_cnt++;
      $display("FAIL single_write_owner: got %0d expected 0", owner);
    end
  endtask

  task automatic test_read_slow();
    int owner;
    req_v      = 4'b0100;
    we_a[2]    = 1'b0;
    addr_a[2]  = 7'h08;
    run_txn(0, 1'b0, 5, 8'hA5, 1'b0, 1'b0, 1'b0, owner);
    cmp_cnt++;
    if (owner != 2) begin
      fail_cnt++;
      $display("FAIL read_slow_owner: got %0d expected 2", owner);
    end
  endtask

  task automatic test_round_robin();
    int owner;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    req_v = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      run_txn(0, 1'b0, 0, DW'($urandom), 1'($urandom), 1'b1, 1'b0, owner);
      cmp_cnt++;
      if (owner != exp_order[n]) begin
        fail_cnt++;
        $display("FAIL rr_order step %0d: got %0d expected %0d", n, owner, exp_order[n]);
      end
    end
  endtask

  task automatic test_timeout();
    int owner;
    req_v = 4'b0010;
    run_txn(0, 1'b1, 0, 8'hEE, 1'b1, 1'b0, 1'b0, owner);
    // the following arbitration proceeds normally
    req_v = 4'b1001;
    run_txn(1, 1'b0, 2, 8'h42, 1'b1, 1'b0, 1'b0, owner);
    cmp_cnt++;
    if (owner != 3) begin
      fail_cnt++;
      $display("FAIL after_timeout_owner: got %0d expected 3", owner);
    end
  endtask

  task automatic test_rvalid_at_timeout();
    int owner;
    idle_cycles(3, 1'b1);
    req_v = 4'b1000;
    run_txn(0, 1'b0, TIMEOUT - 1, 8'h3C, 1'b1, 1'b0, 1'b1, owner);
    req_v = 4'b0100;
    run_txn(3, 1'b0, TIMEOUT - 4, 8'hC3, 1'b0, 1'b0, 1'b1, owner);
    req_v = 4'b0010;
    run_txn(3, 1'b0, TIMEOUT - 3, 8'h99, 1'b1, 1'b0, 1'b1, owner);
    idle_cycles(2, 1'b1);
  endtask

  task automatic test_reset_midflight();
    int owner;
    req_v      = 4'b0100;
    we_a[2]    = 1'b1;
    addr_a[2]  = 7'h08;
    wdata_a[2] = 8'hC3;
    push_req();
    bus.c_ready  = 1'b0;
    bus.c_rvalid = 1'b0;
    @(negedge clk);
    cmp_cnt++;
    if (bus.gnt !== 4'b0100) begin
      fail_cnt++;
      $display("FAIL midrst_gnt: got %b expected 0100", bus.gnt);
    end
    req_v[2] = 1'b0;
    push_req();
    bus.c_ready = 1'b1;
    @(negedge clk);
    bus.c_ready = 1'b0;
    cmp_cnt++;
    if ({bus.busy, bus.c_valid} !== 2'b10) begin
      fail_cnt++;
      $display("FAIL midrst_wait: got busy=%b c_valid=%b expected 1/0", bus.busy, bus.c_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    cmp_cnt++;
    if ({bus.gnt, bus.done, bus.busy, bus.c_valid, bus.c_we, bus.c_addr, bus.c_wdata,
         bus.rsp_rdata, bus.rsp_hit, bus.rsp_err} !== '0) begin
      fail_cnt++;
      $display("FAIL midrst_async: got gnt=%b done=%b busy=%b c_valid=%b c_we=%b c_addr=%h c_wdata=%h rsp=%h/%b/%b expected all 0",
               bus.gnt, bus.done, bus.busy, bus.c_valid, bus.c_we, bus.c_addr, bus.c_wdata,
               bus.rsp_rdata, bus.rsp_hit, bus.rsp_err);
    end
    @(negedge clk);
    bus.c_rvalid = 1'b1;
    bus.c_rdata  = 8'h77;
    @(negedge clk);
    bus.c_rvalid = 1'b0;
    rst_n = 1'b1;
    model_reset();
    idle_cycles(2, 1'b0);
    req_v = 4'b1111;
    run_txn(0, 1'b0, 1, 8'h5C, 1'b1, 1'b0, 1'b0, owner);
    cmp_cnt++;
    if (owner != 0) begin
      fail_cnt++;
      $display("FAIL midrst_first_owner: got %0d expected 0", owner);
    end
  endtask

  task automatic test_random();
    int owner;
    for (int t = 0; t < 40; t++) begin
      req_v = req_v | NREQ'($urandom);
      run_txn($urandom_range(0, TIMEOUT - 1), ($urandom_range(0, 7) == 0),
              $urandom_range(0, TIMEOUT), DW'($urandom), 1'($urandom),
              ($urandom_range(0, 3) == 0), 1'($urandom), owner);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_slow();
    test_round_robin();
    test_timeout();
    test_rvalid_at_timeout();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
